// File: rtl/sb_pkg.sv
// ----------------------------------------------------------------------------
// sb_pkg
// Shared types and constants for the post-commit store buffer.
//   sb_entry_t : one buffered store {addr, data} at the default widths
//   SB_PTR_W   : pointer width (index bits + wrap bit) for the default depth
//   sb_state_e : drain FSM states
// ----------------------------------------------------------------------------
package sb_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int SB_ADDR_W    = 32;
    localparam int SB_DATA_W    = 32;
    localparam int SB_PTR_W     = $clog2(SB_DEPTH_DEF) + 1;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    typedef enum logic [0:0] {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// ----------------------------------------------------------------------------
// sb_fwd_match
// Age-ordered store-to-load forwarding lookup. Scans the live entries oldest
// (rd_ptr) to youngest (wr_ptr-1); a later match overrides an earlier one, so
// the youngest matching store supplies the data.
// Ports:
//   ent_addr_i / ent_data_i : buffer contents
//   valid_i                 : per-entry valid
//   rd_ptr_i / wr_ptr_i     : FIFO pointers including wrap bit
//   ld_addr_i               : load word address
//   hit_o / data_o          : any match / youngest matching data
// ----------------------------------------------------------------------------
module sb_fwd_match #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic [ADDR_W-1:0]            ent_addr_i [SB_DEPTH],
    input  logic [DATA_W-1:0]            ent_data_i [SB_DEPTH],
    input  logic [SB_DEPTH-1:0]          valid_i,
    input  logic [$clog2(SB_DEPTH):0]    rd_ptr_i,
    input  logic [$clog2(SB_DEPTH):0]    wr_ptr_i,
    input  logic [ADDR_W-1:0]            ld_addr_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);

    localparam int IDX_W = $clog2(SB_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        cnt    = wr_ptr_i - rd_ptr_i;
        for (int k = 0; k < SB_DEPTH; k++) begin
            // Offset k from the head; index bits wrap naturally (power-of-2 depth).
            idx = rd_ptr_i[IDX_W-1:0] + IDX_W'(k);
            if ((PTR_W'(k) < cnt) && valid_i[idx] && (ent_addr_i[idx] == ld_addr_i)) begin
                hit_o  = 1'b1;
                data_o = ent_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
// Post-commit store buffer. Accepts one committed store per cycle from the
// ROB, holds it in a circular FIFO and drains oldest-first to the D-cache over
// a req/ack handshake. Only committed stores live here, so there is no flush.
// Ports:
//   rob_commitmemwrite/rob_swaddr/prf_sw_data : push side
//   sb_full / sb_empty                        : occupancy (from current pointers)
//   sb_dc_wr_req/sb_dc_addr/sb_dc_data        : head write request, stable until ack
//   dc_sb_wr_ack                              : D-cache accepts head
//   lsq_ld_addr / sb_ld_hit / sb_ld_data      : load forwarding lookup
// Build option: define SB_LD_FWD_EN to build the forwarding comparators;
// otherwise sb_ld_hit/sb_ld_data are tied to zero.
// ----------------------------------------------------------------------------
module store_buffer
    import sb_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              rob_commitmemwrite,
    input  logic [ADDR_W-1:0] rob_swaddr,
    input  logic [DATA_W-1:0] prf_sw_data,
    output logic              sb_full,
    output logic              sb_empty,
    output logic              sb_dc_wr_req,
    output logic [ADDR_W-1:0] sb_dc_addr,
    output logic [DATA_W-1:0] sb_dc_data,
    input  logic              dc_sb_wr_ack,
    input  logic [ADDR_W-1:0] lsq_ld_addr,
    output logic              sb_ld_hit,
    output logic [DATA_W-1:0] sb_ld_data
);

    localparam int IDX_W = $clog2(SB_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0]   addr_q [SB_DEPTH];
    logic [DATA_W-1:0]   data_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    sb_state_e           state_q, state_d;

    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic                push_ok, pop;

    assign wr_idx   = wr_ptr_q[IDX_W-1:0];
    assign rd_idx   = rd_ptr_q[IDX_W-1:0];

    // Wrap bits differ with equal index bits => every slot is occupied.
    assign sb_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
    assign sb_empty = (wr_ptr_q == rd_ptr_q);

    // Full is judged before the pop, so a same-cycle ack never makes room.
    assign push_ok  = rob_commitmemwrite && !sb_full;
    assign pop      = dc_sb_wr_ack && (state_q == SB_REQ);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        valid_d  = valid_q;
        if (pop)     valid_d[rd_idx] = 1'b0;
        if (push_ok) valid_d[wr_idx] = 1'b1;

        state_d = state_q;
        case (state_q)
            // IDLE only when empty, so a push is the only way to gain an entry.
            SB_IDLE: if (push_ok) state_d = SB_REQ;
            SB_REQ:  if (pop && (wr_ptr_d == rd_ptr_d)) state_d = SB_IDLE;
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            state_q  <= SB_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            state_q  <= state_d;
        end
    end

    // Payload storage is not reset; validity is tracked by the pointers/valid bits.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_idx] <= rob_swaddr;
            data_q[wr_idx] <= prf_sw_data;
        end
    end

    assign sb_dc_wr_req = (state_q == SB_REQ);
    assign sb_dc_addr   = sb_dc_wr_req ? addr_q[rd_idx] : '0;
    assign sb_dc_data   = sb_dc_wr_req ? data_q[rd_idx] : '0;

`ifdef SB_LD_FWD_EN
    sb_fwd_match #(
        .SB_DEPTH (SB_DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) u_fwd (
        .ent_addr_i (addr_q),
        .ent_data_i (data_q),
        .valid_i    (valid_q),
        .rd_ptr_i   (rd_ptr_q),
        .wr_ptr_i   (wr_ptr_q),
        .ld_addr_i  (lsq_ld_addr),
        .hit_o      (sb_ld_hit),
        .data_o     (sb_ld_data)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^{lsq_ld_addr, valid_q};
    assign sb_ld_hit  = 1'b0;
    assign sb_ld_data = '0;
`endif

    // The ROB must never commit a store into a full buffer; the push is dropped.
    push_while_full_a: assert property (@(posedge clk) disable iff (!rst_b)
        !(rob_commitmemwrite && sb_full))
        else $warning("store_buffer: push while full dropped");

endmodule
